funnel_dat_n_1_ser: RTL and testbench



---
 rtl/funnel_pkg.sv | 48 ++++
 rtl/funnel_lane_mux.sv | 29 ++
 rtl/funnel_dat_n_1_ser.sv | 140 ++++++++++++++
 tb/tb_funnel_dat_n_1_ser.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/funnel_pkg.sv
// -----------------------------------------------------------------------------
// funnel_pkg
// Shared definitions for the N:1 data funnel:
//   - config byte bit positions and mode encodings
//   - FSM state type
//   - beat-plan helpers (beats per word, first lane of a word)
// -----------------------------------------------------------------------------
package funnel_pkg;

  // Config byte layout: [0] mode, [1] reverse, [3:2] reserved, [7:4] field F.
  localparam int MODE_BIT = 0;
  localparam int REV_BIT  = 1;
  localparam int F_LSB    = 4;
  localparam int F_MSB    = 7;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_SERIAL = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int field_f(input logic [7:0] cfg);
    return int'(cfg[F_MSB:F_LSB]);
  endfunction

  // Number of output beats one word produces under config cfg.
  function automatic int beat_count(input logic [7:0] cfg, input int num_lanes);
    int f;
    f = field_f(cfg);
    if (cfg[MODE_BIT] == MODE_SELECT) begin
      return 1;
    end
    return (f + 1 < num_lanes) ? f + 1 : num_lanes;
  endfunction

  // Lane index emitted on the first beat of a word under config cfg.
  function automatic int first_lane(input logic [7:0] cfg, input int num_lanes);
    int f;
    f = field_f(cfg);
    if (cfg[MODE_BIT] == MODE_SELECT) begin
      return (f < num_lanes - 1) ? f : num_lanes - 1;
    end
    return cfg[REV_BIT] ? beat_count(cfg, num_lanes) - 1 : 0;
  endfunction

endpackage

// File: rtl/funnel_lane_mux.sv
// -----------------------------------------------------------------------------
// funnel_lane_mux
// Combinational NUM_LANES:1 lane selector.
// Ports:
//   word  in  NUM_LANES*LANE_W  packed lanes, lane k = word[k*LANE_W +: LANE_W]
//   sel   in  IDX_W             lane index
//   lane  out LANE_W            selected lane (zero when sel >= NUM_LANES)
// -----------------------------------------------------------------------------
module funnel_lane_mux #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 128,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES*LANE_W-1:0] word,
  input  logic [IDX_W-1:0]            sel,
  output logic [LANE_W-1:0]           lane
);

  always_comb begin
    // NOTE: default assignment first so every path drives lane and no latch is inferred.
    lane = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (sel == IDX_W'(k)) begin
        lane = word[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/funnel_dat_n_1_ser.sv
// -----------------------------------------------------------------------------
// funnel_dat_n_1_ser
// Accepts one NUM_LANES x LANE_W word per handshake and emits its lanes on a
// single LANE_W valid/ready stream. Config byte selects SELECT (one chosen lane)
// or SERIAL (C lanes, forward or reverse). Word plan is fixed at capture.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   t_0_dat/valid/ready     input word stream
//   t_cfg_dat/valid         config byte write
//   i_0_dat/valid/ready     registered output lane stream
//   i_0_last                final beat of the current word
//   mode                    current config register
// -----------------------------------------------------------------------------
module funnel_dat_n_1_ser #(
  parameter  int NUM_LANES = 4,
  parameter  int LANE_W    = 128,
  localparam int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_LANES*LANE_W-1:0] t_0_dat,
  input  logic                        t_0_valid,
  output logic                        t_0_ready,
  input  logic [7:0]                  t_cfg_dat,
  input  logic                        t_cfg_valid,
  output logic [LANE_W-1:0]           i_0_dat,
  output logic                        i_0_valid,
  input  logic                        i_0_ready,
  output logic                        i_0_last,
  output logic [7:0]                  mode
);

  import funnel_pkg::*;

  // Wide enough to hold a beat count of NUM_LANES.
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  state_e                      state;
  logic [7:0]                  mode_q;
  logic [NUM_LANES*LANE_W-1:0] word_q;
  logic [IDX_W-1:0]            lane_idx;
  logic [CNT_W-1:0]            remaining;
  logic                        rev_q;
  logic [LANE_W-1:0]           dat_q;
  logic                        valid_q;
  logic                        last_q;

  logic                        handshake;
  logic                        done;
  logic                        advance;
  logic                        capture;
  logic [CNT_W-1:0]            cap_count;
  logic [IDX_W-1:0]            cap_first;
  logic [IDX_W-1:0]            next_idx;
  logic [NUM_LANES*LANE_W-1:0] mux_word;
  logic [IDX_W-1:0]            mux_sel;
  logic [LANE_W-1:0]           mux_lane;

  assign handshake = valid_q & i_0_ready;
  assign done      = handshake & last_q;
  assign advance   = handshake & ~last_q;

  // Ready while idle, or in the cycle the final beat leaves, so a new word can
  // be taken with no bubble.
  assign t_0_ready = reset_n & ((state == IDLE) | done);
  assign capture   = t_0_valid & t_0_ready;

  // Plan for a word captured this cycle uses the register value before any
  // concurrent config write lands.
  assign cap_count = CNT_W'(beat_count(mode_q, NUM_LANES));
  assign cap_first = IDX_W'(first_lane(mode_q, NUM_LANES));
  assign next_idx  = rev_q ? lane_idx - IDX_W'(1) : lane_idx + IDX_W'(1);

  // One selector serves both paths: on capture the first lane comes straight
  // from the incoming word, otherwise the next lane comes from the buffer.
  assign mux_word = capture ? t_0_dat   : word_q;
  assign mux_sel  = capture ? cap_first : next_idx;

  funnel_lane_mux #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W),
    .IDX_W     (IDX_W)
  ) u_lane_mux (
    .word (mux_word),
    .sel  (mux_sel),
    .lane (mux_lane)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode_q    <= 8'h00;
      lane_idx  <= '0;
      remaining <= '0;
      rev_q     <= 1'b0;
      dat_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (t_cfg_valid) begin
        mode_q <= t_cfg_dat;
      end

      if (capture) begin
        state     <= SEND;
        dat_q     <= mux_lane;
        valid_q   <= 1'b1;
        last_q    <= (cap_count == CNT_W'(1));
        remaining <= cap_count;
        lane_idx  <= cap_first;
        rev_q     <= (mode_q[MODE_BIT] == MODE_SERIAL) & mode_q[REV_BIT];
      end else if (advance) begin
        dat_q     <= mux_lane;
        lane_idx  <= next_idx;
        remaining <= remaining - CNT_W'(1);
        last_q    <= (remaining == CNT_W'(2));
      end else if (done) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  // NOTE: the word buffer is pure datapath and is not reset; it is only read
  // while a word is in flight, and reset returns the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (capture) begin
      word_q <= t_0_dat;
    end
  end

  assign i_0_dat   = dat_q;
  assign i_0_valid = valid_q;
  assign i_0_last  = last_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_funnel_dat_n_1_ser.sv
// -----------------------------------------------------------------------------
// tb_funnel_dat_n_1_ser
// Self-checking bench: a queue-based beat model predicts outputs every cycle;
// directed scenarios add literal expectations on the observed beat stream.
// -----------------------------------------------------------------------------
module tb_funnel_dat_n_1_ser;

  localparam int NL = 4;
  localparam int LW = 128;

  logic             clk;
  logic             reset_n;
  logic [NL*LW-1:0] t_0_dat;
  logic             t_0_valid;
  logic             t_0_ready;
  logic [7:0]       t_cfg_dat;
  logic             t_cfg_valid;
  logic [LW-1:0]    i_0_dat;
  logic             i_0_valid;
  logic             i_0_ready;
  logic             i_0_last;
  logic [7:0]       mode;

  funnel_dat_n_1_ser #(.NUM_LANES(NL), .LANE_W(LW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .t_0_dat     (t_0_dat),
    .t_0_valid   (t_0_valid),
    .t_0_ready   (t_0_ready),
    .t_cfg_dat   (t_cfg_dat),
    .t_cfg_valid (t_cfg_valid),
    .i_0_dat     (i_0_dat),
    .i_0_valid   (i_0_valid),
    .i_0_ready   (i_0_ready),
    .i_0_last    (i_0_last),
    .mode        (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [LW-1:0] dat;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [7:0]    m_mode = 8'h00;
  logic          exp_ready;
  bit            cap_flag = 0;
  logic [LW-1:0] seen[$];
  logic          seen_last[$];

  // Expand one captured word into its list of output beats.
  function automatic void plan(input logic [7:0] cfg, input logic [NL*LW-1:0] w);
    int    f;
    int    c;
    int    ln;
    beat_t b;
    f = int'(cfg[7:4]);
    if (!cfg[0]) begin
      ln = (f > NL - 1) ? NL - 1 : f;
      b.dat = w[ln*LW +: LW];
      b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      c = (f + 1 > NL) ? NL : f + 1;
      for (int i = 0; i < c; i++) begin
        ln = cfg[1] ? c - 1 - i : i;
        b.dat = w[ln*LW +: LW];
        b.last = (i == c - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Inputs only change just after posedge, so at negedge they already hold
  // the values the next edge will sample.
  always @(negedge clk) begin
    exp_ready = reset_n && (exp_q.size() == 0 || (exp_q.size() == 1 && i_0_ready));
    check("t_0_ready", LW'(t_0_ready), LW'(exp_ready));
    check("mode", LW'(mode), LW'(m_mode));
    if (exp_q.size() > 0) begin
      check("i_0_valid", LW'(i_0_valid), LW'(1'b1));
      check("i_0_dat", i_0_dat, exp_q[0].dat);
      check("i_0_last", LW'(i_0_last), LW'(exp_q[0].last));
    end else begin
      check("i_0_valid_idle", LW'(i_0_valid), LW'(1'b0));
      check("i_0_last_idle", LW'(i_0_last), LW'(1'b0));
    end
    if (reset_n && i_0_valid && i_0_ready) begin
      seen.push_back(i_0_dat);
      seen_last.push_back(i_0_last);
    end
    cap_flag = 0;
    if (!reset_n) begin
      exp_q.delete();
      m_mode = 8'h00;
    end else begin
      if (exp_q.size() > 0 && i_0_ready) void'(exp_q.pop_front());
      if (t_0_valid && exp_ready) begin
        plan(m_mode, t_0_dat);
        cap_flag = 1;
      end
      if (t_cfg_valid) m_mode = t_cfg_dat;
    end
  end

  // ---------------- output ready pattern ----------------
  bit       stall_en = 0;
  logic [3:0] pat = 4'b1001;   // cycle 0:1, 1:0, 2:0, 3:1
  int       cyc = 0;

  always @(posedge clk) begin
    #1;
    if (stall_en) begin
      i_0_ready = pat[cyc];
      cyc = (cyc + 1) % 4;
    end else begin
      i_0_ready = 1'b1;
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [NL*LW-1:0] make_word(input logic [31:0] base);
    logic [NL*LW-1:0] w;
    for (int k = 0; k < NL; k++) begin
      w[k*LW +: LW] = {4{base + 32'(k)}};
    end
    return w;
  endfunction

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] v);
    t_cfg_dat   = v;
    t_cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    t_cfg_valid = 1'b0;
  endtask

  // Present a word until the model sees it captured; returns edges waited.
  task automatic send_word(input logic [NL*LW-1:0] w, input bit cfg_v,
                           input logic [7:0] cfg_d, output int waits);
    waits       = -1;
    t_0_dat     = w;
    t_0_valid   = 1'b1;
    t_cfg_dat   = cfg_d;
    t_cfg_valid = cfg_v;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (cap_flag) begin
        waits = i;
        break;
      end
    end
    if (waits < 0) check("capture_timeout", LW'(cap_flag), LW'(1'b1));
    #1;
    t_0_valid   = 1'b0;
    t_cfg_valid = 1'b0;
  endtask

  int w8;
  int nl;

  initial begin
    reset_n     = 1'b0;
    t_0_dat     = '0;
    t_0_valid   = 1'b0;
    t_cfg_dat   = 8'h00;
    t_cfg_valid = 1'b0;
    i_0_ready   = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ready_low", LW'(t_0_ready), LW'(1'b0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", LW'(i_0_valid), LW'(1'b0));
    check("rst_mode", LW'(mode), LW'(8'h00));
    check("rst_ready_high", LW'(t_0_ready), LW'(1'b1));
    drain(1);

    // SELECT lane 0, eight back-to-back words.
    seen.delete(); seen_last.delete();
    for (int w = 0; w < 8; w++) begin
      send_word(make_word(32'hA0 + 32'(w) * 32'h100), 1'b0, 8'h00, w8);
      check("sel_b2b_wait", LW'(w8), LW'(0));
    end
    drain(3);
    check("sel_count", LW'(seen.size()), LW'(8));
    check("sel_first", seen[0], {4{32'h000000A0}});
    check("sel_eighth", seen[7], {4{32'h000007A0}});
    nl = 0;
    foreach (seen_last[i]) if (seen_last[i]) nl++;
    check("sel_lasts", LW'(nl), LW'(8));

    // SERIAL F=3, two back-to-back words.
    write_cfg(8'h31);
    seen.delete(); seen_last.delete();
    send_word(make_word(32'hA0), 1'b0, 8'h00, w8);
    send_word(make_word(32'hB0), 1'b0, 8'h00, w8);
    check("ser_word2_wait", LW'(w8), LW'(3));
    drain(8);
    check("ser_count", LW'(seen.size()), LW'(8));
    check("ser_b1", seen[0], {4{32'h000000A0}});
    check("ser_b4", seen[3], {4{32'h000000A3}});
    check("ser_b5", seen[4], {4{32'h000000B0}});
    check("ser_b8", seen[7], {4{32'h000000B3}});
    check("ser_last4", LW'(seen_last[3]), LW'(1'b1));
    check("ser_last5", LW'(seen_last[4]), LW'(1'b0));
    check("ser_last8", LW'(seen_last[7]), LW'(1'b1));

    // SERIAL reverse F=1.
    write_cfg(8'h13);
    seen.delete(); seen_last.delete();
    send_word(make_word(32'hC0), 1'b0, 8'h00, w8);
    drain(4);
    check("rev_count", LW'(seen.size()), LW'(2));
    check("rev_b1", seen[0], {4{32'h000000C1}});
    check("rev_b2", seen[1], {4{32'h000000C0}});

    // SERIAL F=15 clamps to NUM_LANES beats.
    write_cfg(8'hF1);
    seen.delete(); seen_last.delete();
    send_word(make_word(32'hD0), 1'b0, 8'h00, w8);
    drain(6);
    check("clamp_count", LW'(seen.size()), LW'(4));
    check("clamp_b4", seen[3], {4{32'h000000D3}});

    // SELECT F=9 clamps to the top lane.
    write_cfg(8'h90);
    seen.delete(); seen_last.delete();
    send_word(make_word(32'hE0), 1'b0, 8'h00, w8);
    drain(3);
    check("selclamp_count", LW'(seen.size()), LW'(1));
    check("selclamp_lane", seen[0], {4{32'h000000E3}});

    // SERIAL with output stalls.
    write_cfg(8'h31);
    seen.delete(); seen_last.delete();
    cyc = 0;
    stall_en = 1;
    send_word(make_word(32'h50), 1'b0, 8'h00, w8);
    drain(14);
    stall_en = 0;
    drain(1);
    check("stall_count", LW'(seen.size()), LW'(4));
    check("stall_b2", seen[1], {4{32'h00000051}});
    check("stall_b4", seen[3], {4{32'h00000053}});
    check("stall_last3", LW'(seen_last[2]), LW'(1'b0));
    check("stall_last4", LW'(seen_last[3]), LW'(1'b1));

    // Config write in the capture cycle affects only the following word.
    seen.delete(); seen_last.delete();
    send_word(make_word(32'h60), 1'b1, 8'h00, w8);
    @(negedge clk);
    check("cfgcap_mode", LW'(mode), LW'(8'h00));
    drain(5);
    send_word(make_word(32'h70), 1'b0, 8'h00, w8);
    drain(3);
    check("cfgcap_count", LW'(seen.size()), LW'(5));
    check("cfgcap_b4", seen[3], {4{32'h00000063}});
    check("cfgcap_next", seen[4], {4{32'h00000070}});

    // Reset during beat 2 of 4.
    write_cfg(8'h31);
    seen.delete(); seen_last.delete();
    send_word(make_word(32'h80), 1'b0, 8'h00, w8);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", LW'(t_0_ready), LW'(1'b0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", LW'(i_0_valid), LW'(1'b0));
    check("midrst_mode", LW'(mode), LW'(8'h00));
    check("midrst_ready_rel", LW'(t_0_ready), LW'(1'b1));
    drain(5);
    check("midrst_count", LW'(seen.size()), LW'(1));
    check("midrst_b1", seen[0], {4{32'h00000080}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
